// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store memory stage.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_bus_if.sv
// Request/acknowledge data bus between the memory stage (master) and data memory (slave).
interface lsu_bus_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    logic        ack;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        output wmask,
        input  rdata,
        input  ack
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        input  wmask,
        output rdata,
        output ack
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store mask/lane replication/alignment check on the
// request side, and load lane selection with sign/zero extension on the response side.
module lsu_align (
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_offset,
    input  logic [31:0] wdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_rep,
    output logic        misaligned,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);
    import lsu_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        wmask      = 4'b0000;
        wdata_rep  = wdata;
        misaligned = 1'b1;
        case (req_funct3)
            F3_B, F3_BU: begin
                misaligned = 1'b0;
                wmask      = 4'b0001 << req_offset;
                wdata_rep  = {4{wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                misaligned = req_offset[0];
                wmask      = 4'b0011 << req_offset;
                wdata_rep  = {2{wdata[15:0]}};
            end
            F3_W: begin
                misaligned = (req_offset != 2'b00);
                wmask      = 4'b1111;
            end
            default: ;
        endcase
    end

    // Load lanes come from the offset latched with the request, not the live address.
    always_comb begin
        case (ld_offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = ld_offset[1] ? rdata[31:16] : rdata[15:0];
        case (ld_funct3)
            F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ld_data = {24'd0, byte_sel};
            F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ld_data = {16'd0, half_sel};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-access stage: launches aligned loads/stores on the req/ack bus, stalls the
// pipeline while the access is outstanding, and aborts on timeout.
module lsu_mem_stage #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_E,
    input  logic        rd_en_E,
    input  logic        mem_write_E,
    input  logic [2:0]  funct3_E,
    input  logic [31:0] addr_E,
    input  logic [31:0] wdata_E,
    output logic        stall_MW,
    output logic [31:0] load_data,
    output logic        misalign_exc,
    output logic        access_fault,
    lsu_bus_if.master   bus
);
    import lsu_pkg::*;

    lsu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wmask_q, wmask_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       off_q, off_d;
    logic [31:0]      load_data_q, load_data_d;

    logic             access_valid;
    logic             misaligned;
    logic [3:0]       st_wmask;
    logic [31:0]      st_wdata;
    logic [31:0]      ld_data;

    lsu_align u_align (
        .req_funct3 (funct3_E),
        .req_offset (addr_E[1:0]),
        .wdata      (wdata_E),
        .wmask      (st_wmask),
        .wdata_rep  (st_wdata),
        .misaligned (misaligned),
        .ld_funct3  (f3_q),
        .ld_offset  (off_q),
        .rdata      (bus.rdata),
        .ld_data    (ld_data)
    );

    assign access_valid = !cs_E && (rd_en_E || mem_write_E);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        f3_d         = f3_q;
        off_d        = off_q;
        load_data_d  = load_data_q;
        stall_MW     = 1'b0;
        misalign_exc = 1'b0;
        access_fault = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (access_valid && !reset) begin
                    if (misaligned) begin
                        misalign_exc = 1'b1;
                    end else begin
                        stall_MW = 1'b1;
                        state_d  = REQ;
                        cnt_d    = '0;
                        we_d     = mem_write_E;
                        addr_d   = {addr_E[31:2], 2'b00};
                        wdata_d  = st_wdata;
                        wmask_d  = mem_write_E ? st_wmask : 4'b0000;
                        f3_d     = funct3_E;
                        off_d    = addr_E[1:0];
                    end
                end
            end
            REQ: begin
                stall_MW = 1'b1;
                if (bus.ack) begin
                    state_d = DONE;
                    if (!we_q) begin
                        load_data_d = ld_data;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    access_fault = 1'b1;
                    load_data_d  = '0;
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // One unstalled cycle lets the pipeline advance; the access still on the inputs is not relaunched.
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            load_data_q <= load_data_d;
        end
    end

    assign bus.req   = (state_q == REQ);
    assign bus.we    = we_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;
    assign bus.wmask = wmask_q;
    assign load_data = load_data_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: loads, stores, misalignment, timeout and mid-access reset.
module tb_lsu_mem_stage;

    logic        clk;
    logic        reset;
    logic        cs_E;
    logic        rd_en_E;
    logic        mem_write_E;
    logic [2:0]  funct3_E;
    logic [31:0] addr_E;
    logic [31:0] wdata_E;
    logic        stall_MW;
    logic [31:0] load_data;
    logic        misalign_exc;
    logic        access_fault;

    int checks;
    int errors;

    lsu_bus_if bus_if ();

    lsu_mem_stage #(
        .TIMEOUT_CYCLES (64),
        .CNT_W          (7)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cs_E         (cs_E),
        .rd_en_E      (rd_en_E),
        .mem_write_E  (mem_write_E),
        .funct3_E     (funct3_E),
        .addr_E       (addr_E),
        .wdata_E      (wdata_E),
        .stall_MW     (stall_MW),
        .load_data    (load_data),
        .misalign_exc (misalign_exc),
        .access_fault (access_fault),
        .bus          (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic cs, input logic rd, input logic wr,
                                 input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        cs_E        = cs;
        rd_en_E     = rd;
        mem_write_E = wr;
        funct3_E    = f3;
        addr_E      = addr;
        wdata_E     = wdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Load with ack on the first REQ cycle; pipeline advances during DONE.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] expected);
        applyStimulus(1'b0, 1'b1, 1'b0, f3, addr, 32'h0);
        #1;
        checkOutput({tag, "_stall_idle"}, 32'(stall_MW), 32'd1);
        tick();
        bus_if.ack   = 1'b1;
        bus_if.rdata = rdata;
        #1;
        checkOutput({tag, "_bus_addr"}, bus_if.addr, {addr[31:2], 2'b00});
        checkOutput({tag, "_wmask"}, 32'(bus_if.wmask), 32'h0);
        tick();
        bus_if.ack   = 1'b0;
        bus_if.rdata = 32'h0;
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        checkOutput({tag, "_load_data"}, load_data, expected);
        checkOutput({tag, "_stall_done"}, 32'(stall_MW), 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        bus_if.ack   = 1'b0;
        bus_if.rdata = 32'h0;
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        checkOutput("rst_stall", 32'(stall_MW), 32'd0);
        checkOutput("rst_req", 32'(bus_if.req), 32'd0);
        checkOutput("rst_we", 32'(bus_if.we), 32'd0);
        checkOutput("rst_addr", bus_if.addr, 32'h0);
        checkOutput("rst_wdata", bus_if.wdata, 32'h0);
        checkOutput("rst_wmask", 32'(bus_if.wmask), 32'h0);
        checkOutput("rst_load_data", load_data, 32'h0);
        checkOutput("rst_misalign", 32'(misalign_exc), 32'd0);
        checkOutput("rst_fault", 32'(access_fault), 32'd0);

        // LW 0x100, ack on first REQ cycle, access left on inputs through DONE
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        #1;
        checkOutput("lw_stall_idle", 32'(stall_MW), 32'd1);
        checkOutput("lw_req_idle", 32'(bus_if.req), 32'd0);
        tick();
        bus_if.ack   = 1'b1;
        bus_if.rdata = 32'hDEADBEEF;
        #1;
        checkOutput("lw_req", 32'(bus_if.req), 32'd1);
        checkOutput("lw_stall_req", 32'(stall_MW), 32'd1);
        checkOutput("lw_addr", bus_if.addr, 32'h100);
        checkOutput("lw_we", 32'(bus_if.we), 32'd0);
        checkOutput("lw_wmask", 32'(bus_if.wmask), 32'h0);
        tick();
        bus_if.ack   = 1'b0;
        bus_if.rdata = 32'h0;
        #1;
        checkOutput("lw_stall_done", 32'(stall_MW), 32'd0);
        checkOutput("lw_req_done", 32'(bus_if.req), 32'd0);
        checkOutput("lw_load_data", load_data, 32'hDEADBEEF);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        checkOutput("lw_no_relaunch_req", 32'(bus_if.req), 32'd0);
        checkOutput("lw_held_data", load_data, 32'hDEADBEEF);

        // Misaligned accesses
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
        #1;
        checkOutput("mis_lw_exc", 32'(misalign_exc), 32'd1);
        checkOutput("mis_lw_stall", 32'(stall_MW), 32'd0);
        tick();
        checkOutput("mis_lw_req", 32'(bus_if.req), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        checkOutput("mis_exc_cleared", 32'(misalign_exc), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'b001, 32'h103, 32'h0);
        #1;
        checkOutput("mis_lh_exc", 32'(misalign_exc), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'b011, 32'h100, 32'h0);
        #1;
        checkOutput("mis_f3_011_exc", 32'(misalign_exc), 32'd1);
        checkOutput("mis_f3_011_stall", 32'(stall_MW), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        tick();
        checkOutput("mis_req_after", 32'(bus_if.req), 32'd0);

        // Timeout: no ack for 64 REQ cycles
        applyStimulus(1'b0, 1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        checkOutput("to_req1", 32'(bus_if.req), 32'd1);
        checkOutput("to_fault1", 32'(access_fault), 32'd0);
        for (int k = 2; k <= 63; k++) begin
            tick();
        end
        #1;
        checkOutput("to_fault63", 32'(access_fault), 32'd0);
        checkOutput("to_req63", 32'(bus_if.req), 32'd1);
        tick();
        #1;
        checkOutput("to_fault64", 32'(access_fault), 32'd1);
        checkOutput("to_stall64", 32'(stall_MW), 32'd1);
        tick();
        #1;
        checkOutput("to_stall_done", 32'(stall_MW), 32'd0);
        checkOutput("to_fault_done", 32'(access_fault), 32'd0);
        checkOutput("to_load_data", load_data, 32'h0);
        checkOutput("to_req_done", 32'(bus_if.req), 32'd0);
        tick();

        // Sub-word loads
        do_load("lb", 3'b000, 32'h103, 32'h80FF_0000, 32'hFFFFFF80);
        do_load("lbu", 3'b100, 32'h103, 32'h80FF_0000, 32'h00000080);
        do_load("lhu", 3'b101, 32'h102, 32'h80FF_0000, 32'h000080FF);
        do_load("lh", 3'b001, 32'h102, 32'h80FF_0000, 32'hFFFF80FF);

        // SH 0x202 with delayed ack and inputs changing during REQ
        applyStimulus(1'b0, 1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD);
        #1;
        checkOutput("sh_stall_idle", 32'(stall_MW), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 3'b010, 32'h554, 32'hFFFFFFFF);
        #1;
        checkOutput("sh_we", 32'(bus_if.we), 32'd1);
        checkOutput("sh_wmask", 32'(bus_if.wmask), 32'hC);
        checkOutput("sh_wdata", bus_if.wdata, 32'hABCDABCD);
        checkOutput("sh_addr", bus_if.addr, 32'h200);
        tick();
        bus_if.ack = 1'b1;
        #1;
        checkOutput("sh_addr_stable", bus_if.addr, 32'h200);
        checkOutput("sh_wmask_stable", 32'(bus_if.wmask), 32'hC);
        checkOutput("sh_we_stable", 32'(bus_if.we), 32'd1);
        tick();
        bus_if.ack = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        checkOutput("sh_stall_done", 32'(stall_MW), 32'd0);
        checkOutput("sh_load_data_kept", load_data, 32'hFFFF80FF);
        tick();

        // SB with rd_en and mem_write both set: store wins
        applyStimulus(1'b0, 1'b1, 1'b1, 3'b000, 32'h101, 32'h123456EF);
        #1;
        checkOutput("sb_misalign", 32'(misalign_exc), 32'd0);
        tick();
        bus_if.ack = 1'b1;
        #1;
        checkOutput("sb_we", 32'(bus_if.we), 32'd1);
        checkOutput("sb_wmask", 32'(bus_if.wmask), 32'h2);
        checkOutput("sb_wdata", bus_if.wdata, 32'hEFEFEFEF);
        checkOutput("sb_addr", bus_if.addr, 32'h100);
        tick();
        bus_if.ack = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        checkOutput("sb_load_data_kept", load_data, 32'hFFFF80FF);
        tick();

        // Reset during the third REQ cycle, then a late ack
        applyStimulus(1'b0, 1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
        tick();
        tick();
        tick();
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        checkOutput("rstm_req_before", 32'(bus_if.req), 32'd1);
        tick();
        #1;
        checkOutput("rstm_req", 32'(bus_if.req), 32'd0);
        checkOutput("rstm_stall", 32'(stall_MW), 32'd0);
        checkOutput("rstm_addr", bus_if.addr, 32'h0);
        checkOutput("rstm_load_data", load_data, 32'h0);
        reset        = 1'b0;
        bus_if.ack   = 1'b1;
        bus_if.rdata = 32'h12345678;
        #1;
        checkOutput("rstm_late_ack_req", 32'(bus_if.req), 32'd0);
        tick();
        bus_if.ack = 1'b0;
        #1;
        checkOutput("rstm_late_ack_data", load_data, 32'h0);
        checkOutput("rstm_late_ack_stall", 32'(stall_MW), 32'd0);
        checkOutput("rstm_late_ack_req2", 32'(bus_if.req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
